// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller: exception codes, vector
// offsets, stall level and the flush FSM state encoding.
package pipe_ctrl_pkg;

    // Level on a stall-request line that asks for a stall.
    localparam logic STOP = 1'b1;

    // Exception codes delivered by the MEM stage.
    localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
    localparam logic [31:0] EXC_INT     = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
    localparam logic [31:0] EXC_RI      = 32'h0000_000a;
    localparam logic [31:0] EXC_OV      = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

    // Offsets from the exception base for the two vectors.
    localparam logic [31:0] VEC_OFF_INT = 32'h0000_0020;
    localparam logic [31:0] VEC_OFF_GEN = 32'h0000_0040;

    // Flush down-counter width; enough for the largest flush length of 15.
    localparam int FLUSH_CNT_W = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } flush_state_e;

endpackage

// File: rtl/pipe_ctrl_stall_mask_gen.sv
// Thermometer encoder: every stage at or below the highest requesting stage
// is stalled, so an upstream stage never advances into a frozen one.
import pipe_ctrl_pkg::*;

module stall_mask_gen #(
    parameter int N_STAGE = 6
) (
    input  logic [N_STAGE-1:0] i_stallreq,
    output logic [N_STAGE-1:0] o_stall
);

    logic w_seen;

    // Walk from WB down to PC; once a request is seen, all lower bits stall.
    always_comb begin
        w_seen  = 1'b0;
        o_stall = '0;
        for (int i = N_STAGE - 1; i >= 0; i--) begin
            w_seen     = w_seen | (i_stallreq[i] == STOP);
            o_stall[i] = w_seen;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall mask, exception flush/redirect FSM, stall
// watchdog and accepted-exception counter. All outputs are forced low while
// reset is held.
import pipe_ctrl_pkg::*;

module pipe_ctrl #(
    parameter int N_STAGE      = 6,
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 1,
    parameter int STALL_TO     = 1024,
    parameter int CNT_W        = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [N_STAGE-1:0]  i_stallreq,
    input  logic [31:0]         i_except_type,
    input  logic [ADDR_W-1:0]   i_cp0_epc,
    input  logic [ADDR_W-1:0]   i_ebase,
    output logic [N_STAGE-1:0]  o_stall,
    output logic                o_flush,
    output logic [ADDR_W-1:0]   o_new_pc,
    output logic                o_busy,
    output logic                o_stall_timeout,
    output logic [CNT_W-1:0]    o_exc_count
);

    localparam int WD_W = (STALL_TO < 2) ? 1 : $clog2(STALL_TO + 1);

    flush_state_e           r_state;
    flush_state_e           w_next_state;
    logic [FLUSH_CNT_W-1:0] r_flush_cnt;
    logic [ADDR_W-1:0]      r_target;
    logic [WD_W-1:0]        r_wd;
    logic                   r_timeout;
    logic [CNT_W-1:0]       r_exc_count;

    logic [N_STAGE-1:0]     w_mask;
    logic [N_STAGE-1:0]     w_stall;
    logic [ADDR_W-1:0]      w_vector;
    logic [ADDR_W-1:0]      w_new_pc;
    logic                   w_flush;
    logic                   w_busy;
    logic                   w_exc_pending;
    logic                   w_accept;

    stall_mask_gen #(
        .N_STAGE (N_STAGE)
    ) u_stall_mask_gen (
        .i_stallreq (i_stallreq),
        .o_stall    (w_mask)
    );

    assign w_exc_pending = (i_except_type != EXC_NONE);
    // An exception is taken only from IDLE; a flush in progress ignores new ones.
    assign w_accept      = (r_state == ST_IDLE) && w_exc_pending && !i_rst;

    // Redirect target for the exception currently presented.
    always_comb begin
        case (i_except_type)
            EXC_INT:  w_vector = i_ebase + ADDR_W'(VEC_OFF_INT);
            EXC_ERET: w_vector = i_cp0_epc;
            EXC_SYSCALL, EXC_RI, EXC_OV, EXC_TRAP:
                      w_vector = i_ebase + ADDR_W'(VEC_OFF_GEN);
            default:  w_vector = i_ebase + ADDR_W'(VEC_OFF_GEN);
        endcase
    end

    // Flush FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    // Flush FSM next-state logic; a one-cycle flush never leaves IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept && (FLUSH_CYCLES > 1)) w_next_state = ST_FLUSH;
            ST_FLUSH: if (r_flush_cnt == FLUSH_CNT_W'(1)) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Flush FSM outputs; an exception in IDLE redirects in the same cycle and
    // overrides any stall request.
    always_comb begin
        w_flush  = 1'b0;
        w_new_pc = '0;
        w_stall  = '0;
        w_busy   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_exc_pending) begin
                    w_flush  = 1'b1;
                    w_new_pc = w_vector;
                end else begin
                    w_stall  = w_mask;
                end
            end
            ST_FLUSH: begin
                w_flush  = 1'b1;
                w_new_pc = r_target;
                w_busy   = 1'b1;
            end
            default: ;
        endcase
    end

    // Remaining extra flush cycles after the accept cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_flush_cnt <= '0;
        else if (w_accept)
            r_flush_cnt <= FLUSH_CNT_W'(FLUSH_CYCLES - 1);
        else if ((r_state == ST_FLUSH) && (r_flush_cnt != '0))
            r_flush_cnt <= r_flush_cnt - FLUSH_CNT_W'(1);
    end

    // Hold the redirect target so later flush cycles keep presenting it.
    always_ff @(posedge i_clk) begin
        if (i_rst)         r_target <= '0;
        else if (w_accept) r_target <= w_vector;
    end

    // Count accepted exceptions other than eret, saturating at all-ones.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_exc_count <= '0;
        else if (w_accept && (i_except_type != EXC_ERET) && (r_exc_count != '1))
            r_exc_count <= r_exc_count + CNT_W'(1);
    end

    // Consecutive-stall watchdog; the flag is sticky until reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wd      <= '0;
            r_timeout <= 1'b0;
        end else if (STALL_TO != 0) begin
            if (w_stall == '0) begin
                r_wd <= '0;
            end else if (r_wd != WD_W'(STALL_TO)) begin
                r_wd <= r_wd + WD_W'(1);
                if (r_wd == WD_W'(STALL_TO - 1)) r_timeout <= 1'b1;
            end
        end
    end

    assign o_stall         = i_rst ? '0   : w_stall;
    assign o_flush         = i_rst ? 1'b0 : w_flush;
    assign o_new_pc        = i_rst ? '0   : w_new_pc;
    assign o_busy          = i_rst ? 1'b0 : w_busy;
    assign o_stall_timeout = i_rst ? 1'b0 : r_timeout;
    assign o_exc_count     = i_rst ? '0   : r_exc_count;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl. Two instances share the inputs:
//   A: FLUSH_CYCLES=1, STALL_TO=4, CNT_W=3  (short watchdog, counter saturates)
//   B: FLUSH_CYCLES=3, STALL_TO=0, CNT_W=16 (multi-cycle flush, watchdog off)
module tb_pipe_ctrl;

    // ---------------- clock / reset / inputs ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  sreq = '0;
    logic [31:0] exc = '0;
    logic [31:0] epc = '0;
    logic [31:0] ebase = '0;

    always #5 clk = ~clk;

    logic [5:0]  a_stall, b_stall;
    logic        a_flush, b_flush, a_busy, b_busy, a_to, b_to;
    logic [31:0] a_new_pc, b_new_pc;
    logic [2:0]  a_cnt;
    logic [15:0] b_cnt;

    pipe_ctrl #(.N_STAGE(6), .ADDR_W(32), .FLUSH_CYCLES(1), .STALL_TO(4), .CNT_W(3)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_stallreq(sreq), .i_except_type(exc),
        .i_cp0_epc(epc), .i_ebase(ebase), .o_stall(a_stall), .o_flush(a_flush),
        .o_new_pc(a_new_pc), .o_busy(a_busy), .o_stall_timeout(a_to), .o_exc_count(a_cnt));

    pipe_ctrl #(.N_STAGE(6), .ADDR_W(32), .FLUSH_CYCLES(3), .STALL_TO(0), .CNT_W(16)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_stallreq(sreq), .i_except_type(exc),
        .i_cp0_epc(epc), .i_ebase(ebase), .o_stall(b_stall), .o_flush(b_flush),
        .o_new_pc(b_new_pc), .o_busy(b_busy), .o_stall_timeout(b_to), .o_exc_count(b_cnt));

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- reference model ----------------
    // Per instance: flush cycles still owed, held target, consecutive stalled
    // cycles, sticky timeout, exception count.
    int          cfg_flush[2] = '{1, 3};
    int          cfg_sto[2]   = '{4, 0};
    int          cfg_cmax[2]  = '{7, 65535};
    int          m_left[2]    = '{0, 0};
    int          m_wd[2]      = '{0, 0};
    int          m_cnt[2]     = '{0, 0};
    bit          m_to[2]      = '{0, 0};
    logic [31:0] m_tgt[2]     = '{32'h0, 32'h0};

    function automatic logic [5:0] thermo(input logic [5:0] req);
        logic [5:0] m = '0;
        for (int k = 0; k < 6; k++)
            if (req[k]) m = 6'((1 << (k + 1)) - 1);
        return m;
    endfunction

    function automatic logic [31:0] vec_of(input logic [31:0] code);
        if (code == 32'h01) return ebase + 32'h20;
        if (code == 32'h0e) return epc;
        return ebase + 32'h40;
    endfunction

    // Packed expectation: {stall[56:51], flush[50], pc[49:18], busy[17], to[16], cnt[15:0]}
    function automatic logic [56:0] model_out(input int j);
        logic [5:0]  s  = '0;
        logic        f  = 1'b0;
        logic [31:0] pc = '0;
        if (rst) return '0;
        if (m_left[j] > 0) begin
            f = 1'b1; pc = m_tgt[j];
        end else if (exc != 0) begin
            f = 1'b1; pc = vec_of(exc);
        end else begin
            s = thermo(sreq);
        end
        return {s, f, pc, 1'(m_left[j] > 0), 1'(m_to[j]), 16'(m_cnt[j])};
    endfunction

    task automatic model_update(input int j);
        logic [56:0] o = model_out(j);
        if (rst) begin
            m_left[j] = 0; m_wd[j] = 0; m_cnt[j] = 0; m_to[j] = 0; m_tgt[j] = '0;
        end else begin
            if (m_left[j] > 0) begin
                m_left[j]--;
            end else if (exc != 0) begin
                m_tgt[j]  = vec_of(exc);
                m_left[j] = cfg_flush[j] - 1;
                if (exc != 32'h0e && m_cnt[j] < cfg_cmax[j]) m_cnt[j]++;
            end
            if (o[56:51] == 6'd0 || cfg_sto[j] == 0) begin
                m_wd[j] = 0;
            end else begin
                if (m_wd[j] < cfg_sto[j]) m_wd[j]++;
                if (m_wd[j] == cfg_sto[j]) m_to[j] = 1'b1;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        model_update(0);
        model_update(1);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; sreq = '0; exc = '0; epc = '0; ebase = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; sreq = 6'b100000; exc = 32'h01; ebase = 32'h1000;
        @(negedge clk);
        n_checks++;
        if ({a_stall, a_flush, a_new_pc, a_busy, a_to, a_cnt} !== '0)
            $display("FAIL reset_outs_a: got %h required 0", {a_stall, a_flush, a_new_pc, a_busy, a_to, a_cnt});
        else n_pass++;
        n_checks++;
        if ({b_stall, b_flush, b_new_pc, b_busy, b_to, b_cnt} !== '0)
            $display("FAIL reset_outs_b: got %h required 0", {b_stall, b_flush, b_new_pc, b_busy, b_to, b_cnt});
        else n_pass++;
        tick();
        rst = 1'b0; sreq = '0; exc = '0;
        @(negedge clk);
        n_checks++;
        if (a_cnt !== 3'd0 || b_cnt !== 16'd0 || b_busy !== 1'b0 || a_flush !== 1'b0)
            $display("FAIL reset_state: got cnt %0d/%0d busy %b flush %b required 0", a_cnt, b_cnt, b_busy, a_flush);
        else n_pass++;
        tick();
    endtask

    task automatic test_stall_mask();
        logic [5:0] req_t[4] = '{6'b001000, 6'b000100, 6'b001100, 6'b000000};
        logic [5:0] exp_t[4] = '{6'b001111, 6'b000111, 6'b001111, 6'b000000};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            sreq = req_t[i];
            @(negedge clk);
            n_checks++;
            if (a_stall !== exp_t[i] || b_stall !== exp_t[i])
                $display("FAIL stall_mask[%0d]: got %b/%b required %b", i, a_stall, b_stall, exp_t[i]);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_vectors();
        apply_reset();
        ebase = 32'h0; sreq = 6'b001000; exc = 32'h01;
        @(negedge clk);
        n_checks++;
        if (a_flush !== 1'b1 || a_new_pc !== 32'h20 || a_stall !== 6'd0)
            $display("FAIL vec_int: got flush %b pc %h stall %b required 1 00000020 000000", a_flush, a_new_pc, a_stall);
        else n_pass++;
        tick();
        exc = '0; sreq = '0;
        @(negedge clk);
        n_checks++;
        if (a_cnt !== 3'd1 || a_flush !== 1'b0 || a_new_pc !== 32'h0)
            $display("FAIL vec_int_after: got cnt %0d flush %b pc %h required 1 0 0", a_cnt, a_flush, a_new_pc);
        else n_pass++;
        epc = 32'h1234; exc = 32'h0e;
        @(negedge clk);
        n_checks++;
        if (a_new_pc !== 32'h1234) $display("FAIL vec_eret: got %h required 00001234", a_new_pc);
        else n_pass++;
        tick();
        exc = '0;
        @(negedge clk);
        n_checks++;
        if (a_cnt !== 3'd1) $display("FAIL eret_count: got %0d required 1", a_cnt);
        else n_pass++;
        ebase = 32'h8000_0000; exc = 32'h0a;
        @(negedge clk);
        n_checks++;
        if (a_new_pc !== 32'h8000_0040) $display("FAIL vec_ri: got %h required 80000040", a_new_pc);
        else n_pass++;
        tick();
        exc = 32'h1f;
        @(negedge clk);
        n_checks++;
        if (a_new_pc !== 32'h8000_0040) $display("FAIL vec_other: got %h required 80000040", a_new_pc);
        else n_pass++;
        tick();
        exc = '0;
    endtask

    task automatic test_flush_multi();
        logic [31:0] codes[4] = '{32'h08, 32'h0c, 32'h00, 32'h00};
        logic        exp_f[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic        exp_b[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        apply_reset();
        ebase = 32'h0;
        for (int i = 0; i < 4; i++) begin
            exc  = codes[i];
            sreq = (i == 1) ? 6'b100000 : 6'b000000;
            @(negedge clk);
            n_checks++;
            if (b_flush !== exp_f[i] || b_busy !== exp_b[i] || b_stall !== 6'd0 ||
                b_new_pc !== (exp_f[i] ? 32'h40 : 32'h0))
                $display("FAIL flush3[%0d]: got flush %b busy %b stall %b pc %h required %b %b 0",
                         i, b_flush, b_busy, b_stall, b_new_pc, exp_f[i], exp_b[i]);
            else n_pass++;
            tick();
        end
        @(negedge clk);
        n_checks++;
        if (b_cnt !== 16'd1) $display("FAIL flush3_count: got %0d required 1", b_cnt);
        else n_pass++;
    endtask

    task automatic test_watchdog();
        apply_reset();
        sreq = 6'b000001;
        for (int i = 0; i < 3; i++) tick();
        sreq = '0;
        tick();
        sreq = 6'b000010;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (a_to !== 1'b0) $display("FAIL wd_early[%0d]: got %b required 0", i, a_to);
            else n_pass++;
            tick();
        end
        sreq = '0;
        @(negedge clk);
        n_checks++;
        if (a_to !== 1'b1) $display("FAIL wd_set: got %b required 1", a_to);
        else n_pass++;
        for (int i = 0; i < 3; i++) tick();
        @(negedge clk);
        n_checks++;
        if (a_to !== 1'b1 || b_to !== 1'b0)
            $display("FAIL wd_sticky: got a %b b %b required 1 0", a_to, b_to);
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (a_to !== 1'b0) $display("FAIL wd_clear: got %b required 0", a_to);
        else n_pass++;
    endtask

    task automatic test_reset_in_flush();
        apply_reset();
        exc = 32'h08;
        tick();
        exc = '0; rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (b_flush !== 1'b0 || b_busy !== 1'b0)
            $display("FAIL rst_flush_hold: got flush %b busy %b required 0 0", b_flush, b_busy);
        else n_pass++;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (b_flush !== 1'b0 || b_busy !== 1'b0)
            $display("FAIL rst_flush_after: got flush %b busy %b required 0 0", b_flush, b_busy);
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        logic [31:0] codes[7] = '{32'h01, 32'h08, 32'h0a, 32'h0c, 32'h0d, 32'h0e, 32'h13};
        logic [56:0] exp_v, got_v;
        int sel;
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            rst   = ($urandom_range(0, 39) == 0);
            sreq  = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom);
            ebase = $urandom & 32'hffff_f000;
            epc   = $urandom;
            sel   = $urandom_range(0, 11);
            if (sel < 4)      exc = codes[sel];
            else if (sel < 7) exc = codes[sel];
            else if (sel < 8) exc = $urandom | 32'h100;
            else              exc = '0;
            @(negedge clk);
            exp_v = model_out(0);
            got_v = {a_stall, a_flush, a_new_pc, a_busy, a_to, 13'd0, a_cnt};
            n_checks++;
            if (got_v !== exp_v) $display("FAIL rand_a[%0d]: got %h required %h", c, got_v, exp_v);
            else n_pass++;
            exp_v = model_out(1);
            got_v = {b_stall, b_flush, b_new_pc, b_busy, b_to, b_cnt};
            n_checks++;
            if (got_v !== exp_v) $display("FAIL rand_b[%0d]: got %h required %h", c, got_v, exp_v);
            else n_pass++;
            tick();
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_stall_mask();
        test_vectors();
        test_flush_multi();
        test_watchdog();
        test_reset_in_flush();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
